// File: rtl/gpio_in_cond.sv
// GPIO receive conditioning: per-bit resynchroniser, programmable stability
// filter and single-cycle rise/fall flags, with a raw test_mode bypass.
module gpio_in_cond #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 4,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pad_i,
  input  logic [WIDTH-1:0] filt_en,
  input  logic [CNT_W-1:0] filt_len,
  input  logic             test_mode,
  output logic [WIDTH-1:0] sig_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] stab_q, stab_d;
  logic [WIDTH-1:0] prev_q;
  logic [CNT_W-1:0] cnt_q  [WIDTH];
  logic [CNT_W-1:0] cnt_d  [WIDTH];
  logic [WIDTH-1:0] s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= {WIDTH{RST_VAL}};
    end else begin
      sync_q[0] <= pad_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // A pending change is accepted once the count reaches filt_len; using >=
  // lets a shortened filt_len take effect on the very next edge.
  always_comb begin
    stab_d = stab_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (!filt_en[i]) begin
        stab_d[i] = s[i];
      end else if (s[i] == stab_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= filt_len) begin
        stab_d[i] = s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_q <= {WIDTH{RST_VAL}};
      prev_q <= {WIDTH{RST_VAL}};
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      stab_q <= stab_d;
      prev_q <= stab_q;
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign sig_o  = test_mode ? pad_i : stab_q;
  assign rise_o = test_mode ? '0 : (stab_q & ~prev_q);
  assign fall_o = test_mode ? '0 : (~stab_q & prev_q);

endmodule

// File: doc/gpio_in_cond.md
# gpio_in_cond

Input-conditioning stage between the GPIO pad cells' receive outputs (`C`) and the `io_pads_gpioA_i_ival` / `io_pads_gpioB_i_ival` inputs of `e203_soc_top`; one instance per GPIO bank. Each bit is resynchronised into the `clk` domain, optionally glitch-filtered by a programmable stability counter, and given single-cycle rise/fall flags. A `test_mode` bypass hands raw pad values straight through for scan/ATPG.

## Interface
Parameters:
- `WIDTH`, 32, number of GPIO bits
- `SYNC_STAGES`, 2, synchroniser depth (legal ≥2)
- `CNT_W`, 4, filter counter width
- `RST_VAL`, 0, reset value of every per-bit state flop (all bits identical)

Ports (one clock; reset asynchronous, active-low):
- `clk`  in  1  core clock
- `rst_n`  in  1  asynchronous active-low reset
- `pad_i`  in  WIDTH  raw pad receive values, asynchronous to `clk`
- `filt_en`  in  WIDTH  per-bit filter enable, quasi-static, `clk` domain
- `filt_len`  in  CNT_W  extra stable cycles required before a filtered bit may change
- `test_mode`  in  1  bypass select
- `sig_o`  out  WIDTH  conditioned value to `e203_soc_top`
- `rise_o`  out  WIDTH  one-cycle flag on a 0→1 change of conditioned value
- `fall_o`  out  WIDTH  one-cycle flag on a 1→0 change of conditioned value

## Operation
- Per-bit state: sync chain `sync[SYNC_STAGES]`, filtered value `stab`, previous value `prev`, counter `cnt[CNT_W]`. `s` = last sync stage.
- Reset (`rst_n`=0, async): sync chain, `stab` and `prev` = `RST_VAL`; `cnt` = 0. Outputs: `sig_o` = `RST_VAL`, `rise_o` = 0, `fall_o` = 0 (when `test_mode`=0).
- Each `clk` edge, the sync chain shifts: `sync[0]` ← `pad_i`.
- Filter update per bit, priority order:
  - `filt_en`=0: `stab` ← `s`; `cnt` ← 0.
  - `s` == `stab`: `cnt` ← 0. A glitch that returns before acceptance is discarded.
  - `cnt` ≥ `filt_len`: `stab` ← `s`; `cnt` ← 0.
  - otherwise: `cnt` ← `cnt`+1.
- The `≥` compare covers a `filt_len` reduction mid-count: the change is accepted on the next edge. A `filt_len` increase simply extends the count. `cnt` never wraps, because it cannot exceed `2^CNT_W-1` before acceptance.
- Toggling `filt_en` 1→0 mid-count: pending `s` is taken on the next edge. Toggling 0→1 starts with `cnt`=0.
- `prev` ← `stab` every edge.
- `rise_o` = `stab & ~prev`; `fall_o` = `~stab & prev`. These are combinational from flops. Each conditioned-value change yields exactly one flag cycle; flags are never both set on one bit.
- `test_mode`=1: `sig_o` = `pad_i` (combinational); `rise_o` = `fall_o` = 0. Internal state keeps updating normally, so deasserting `test_mode` needs no re-init.
- Bits are fully independent. No cross-bit interaction.

## Timing
- Take `pad_i` stable across edge E0, with E0 being the first edge that samples the new value.
- Unfiltered path (`filt_en`=0, or `filt_len`=0): `sig_o` changes after edge E0+SYNC_STAGES. That is SYNC_STAGES+1 edges, i.e. 3 edges at default. `rise_o`/`fall_o` are high for the cycle following that edge.
- Filtered path: `sig_o` changes after edge E0+SYNC_STAGES+`filt_len`.
- Acceptance rule: a level at `s` is accepted only if it holds for `filt_len`+1 consecutive cycles. Shorter pulses produce no `sig_o` change and no flag.
- Minimum pad pulse guaranteed to propagate unfiltered: 1 `clk` period plus setup/hold. Narrower pulses may be lost; this is by design.
- Reset assertion mid-count: state returns to reset values immediately, with no flag. After deassertion, a pad level ≠ `RST_VAL` propagates as a normal change and produces one flag.

## Test plan
- Reset release, `RST_VAL`=0, `pad_i`=0, `filt_en`=0 → `sig_o`=0 and no flags for 20 cycles. Then `pad_i[5]`=1 → `sig_o[5]`=1 after edge 3, `rise_o[5]` high exactly one cycle.
- `filt_en[0]`=1, `filt_len`=4: `pad_i[0]` high for 4 cycles then low → `sig_o[0]` stays 0, no flags. High for 5 cycles → `sig_o[0]`=1 after edge 7, single `rise_o[0]`.
- `filt_len`=15 mid-count at `cnt`=6, then write `filt_len`=3 → accepted on the next edge, one flag.
- `test_mode`=1: `pad_i`=0xA5A5_5A5A → `sig_o`=0xA5A5_5A5A in the same cycle, flags 0. Drop `test_mode` → `sig_o` equals the synchronised state with no spurious flags.
- Assert `rst_n` while bit 3 has `cnt`=2 → `sig_o[3]`=0 and `cnt` cleared asynchronously. With the pad held at 1 through release → exactly one `rise_o[3]` at edge 3 after release.
- Random per-bit toggling on 32 bits with mixed `filt_en`/`filt_len` against a cycle-accurate model → `sig_o`/`rise_o`/`fall_o` match every cycle, and no bit ever has rise and fall together.
